leibniz_series_seq: RTL



---
 rtl/leibniz_series_seq_pkg.sv | 31 +++
 rtl/leibniz_series_seq_if.sv | 15 +
 rtl/leibniz_series_seq_div.sv | 59 +++++
 rtl/leibniz_series_seq.sv | 126 ++++++++++++
 4 files changed

// File: rtl/leibniz_series_seq_pkg.sv
// Shared types and width/constant helpers for the sequential Leibniz series engine.
package leibniz_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    DIV,
    ACC,
    DONE
  } leibniz_state_t;

  // Upper bound on RW for the M constant builder.
  localparam int MAX_W = 128;

  function automatic int rw_f(input int frac_digits);
    return 4 * frac_digits + 3;
  endfunction

  function automatic int dw_f(input int a_width, input int terms);
    return a_width + $clog2(4 * terms);
  endfunction

  // M = 4 * 16^frac_digits is a single set bit at position 4*frac_digits+2.
  function automatic logic [MAX_W-1:0] m_const_f(input int frac_digits);
    logic [MAX_W-1:0] m;
    m = '0;
    m[4 * frac_digits + 2] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/leibniz_series_seq_if.sv
// Start/busy/done handshake and result bus of the Leibniz series engine.
interface leibniz_series_seq_if #(
  parameter int A_WIDTH = 8,
  parameter int RW      = 63
) ();
  logic               start;
  logic [A_WIDTH-1:0] a;
  logic               busy;
  logic               done;
  logic               err;
  logic [RW-1:0]      v;

  modport master (output start, output a, input busy, input done, input err, input v);
  modport slave  (input start, input a, output busy, output done, output err, output v);
endinterface

// File: rtl/leibniz_series_seq_div.sv
// Sequential restoring divider: one quotient bit per step, MSB first.
module restoring_div_seq #(
  parameter int RW = 63,
  parameter int DW = 12
) (
  input  logic          clk_2,
  input  logic          reset_n,
  input  logic          load_i,
  input  logic          step_i,
  input  logic [RW-1:0] dividend_i,
  input  logic [DW-1:0] divisor_i,
  output logic [RW-1:0] q_o,
  output logic [DW-1:0] r_o,
  output logic          last_o
);
  localparam int CW = $clog2(RW);

  logic [RW-1:0] dvd_q;
  logic [RW-1:0] q_q;
  logic [DW-1:0] d_q;
  logic [DW-1:0] r_q;
  logic [CW-1:0] cnt_q;
  logic [DW:0]   r_shift_d;
  logic [DW:0]   r_sub_d;
  logic          ge_d;

  // The partial remainder stays below d, so both candidates fit back into DW bits.
  always_comb begin
    r_shift_d = {r_q, dvd_q[RW-1]};
    ge_d      = (r_shift_d >= {1'b0, d_q});
    r_sub_d   = r_shift_d - {1'b0, d_q};
  end

  always_ff @(posedge clk_2) begin
    if (!reset_n) begin
      dvd_q <= '0;
      q_q   <= '0;
      d_q   <= '0;
      r_q   <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      dvd_q <= dividend_i;
      d_q   <= divisor_i;
      r_q   <= '0;
      q_q   <= '0;
      cnt_q <= CW'(RW - 1);
    end else if (step_i) begin
      dvd_q <= {dvd_q[RW-2:0], 1'b0};
      q_q   <= {q_q[RW-2:0], ge_d};
      r_q   <= ge_d ? r_sub_d[DW-1:0] : r_shift_d[DW-1:0];
      if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
    end
  end

  assign q_o    = q_q;
  assign r_o    = r_q;
  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/leibniz_series_seq.sv
// Alternating-series (Leibniz) evaluator using one shared sequential divider.
// Optional build macro LEIBNIZ_ROUND_EN: round each quotient to nearest instead of truncating.
module leibniz_series_seq
  import leibniz_pkg::*;
#(
  parameter int FRAC_DIGITS = 15,
  parameter int TERMS       = 4,
  parameter int A_WIDTH     = 8
) (
  input logic                clk_2,
  input logic                reset_n,
  leibniz_series_seq_if.slave bus
);
  localparam int RW = rw_f(FRAC_DIGITS);
  localparam int DW = dw_f(A_WIDTH, TERMS);
  localparam int KW = (2 * TERMS > 1) ? $clog2(2 * TERMS) : 1;
  localparam logic [MAX_W-1:0] M_FULL = m_const_f(FRAC_DIGITS);
  localparam logic [RW-1:0]    M      = M_FULL[RW-1:0];
`ifdef LEIBNIZ_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  leibniz_state_t     state_q;
  logic [A_WIDTH-1:0] a_q;
  logic [KW-1:0]      k_q;
  logic [RW-1:0]      acc_q;
  logic [RW-1:0]      v_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;

  logic [DW-1:0]      divisor_d;
  logic [RW-1:0]      q_div;
  logic [DW-1:0]      r_div;
  logic               last_div;
  logic [RW-1:0]      q_adj_d;
  logic [RW-1:0]      acc_d;

  function automatic logic [RW-1:0] round_q_f(input logic [RW-1:0] q,
                                              input logic [DW-1:0] r,
                                              input logic [DW-1:0] d);
    logic up;
    up = ({r, 1'b0} >= {1'b0, d});
    return q + RW'(up);
  endfunction

  // Even k adds M/(a+2k), odd k subtracts it; quotients shrink with k so acc stays in [0, M].
  always_comb begin
    divisor_d = DW'(a_q) + DW'({k_q, 1'b0});
    q_adj_d   = ROUND_EN ? round_q_f(q_div, r_div, divisor_d) : q_div;
    acc_d     = k_q[0] ? (acc_q - q_adj_d) : (acc_q + q_adj_d);
  end

  restoring_div_seq #(
    .RW(RW),
    .DW(DW)
  ) u_div (
    .clk_2     (clk_2),
    .reset_n   (reset_n),
    .load_i    (state_q == SETUP),
    .step_i    (state_q == DIV),
    .dividend_i(M),
    .divisor_i (divisor_d),
    .q_o       (q_div),
    .r_o       (r_div),
    .last_o    (last_div)
  );

  always_ff @(posedge clk_2) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      v_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            busy_q <= 1'b1;
            if (bus.a == '0) begin
              err_q   <= 1'b1;
              v_q     <= '0;
              state_q <= DONE;
            end else begin
              err_q   <= 1'b0;
              a_q     <= bus.a;
              acc_q   <= '0;
              k_q     <= '0;
              state_q <= SETUP;
            end
          end
        end
        SETUP: state_q <= DIV;
        DIV: begin
          if (last_div) state_q <= ACC;
        end
        ACC: begin
          acc_q <= acc_d;
          k_q   <= k_q + KW'(1);
          if (k_q == KW'(2 * TERMS - 1)) state_q <= DONE;
          else                           state_q <= SETUP;
        end
        DONE: begin
          if (!err_q) v_q <= acc_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;
  assign bus.v    = v_q;

endmodule
